// File: rtl/prf_read_arbiter_pkg.sv
// Shared types for the physical-regfile read arbiter: preg index width, CDB broadcast,
// read request bundle and the operand bypass helper.
package prf_read_arbiter_pkg;

  localparam int unsigned PREG_IDX_WIDTH = 6;

  typedef struct packed {
    logic                      valid;
    logic [PREG_IDX_WIDTH-1:0] pd;
    logic [31:0]               value;
  } cdb_t;

  typedef struct packed {
    logic                      valid;
    logic [PREG_IDX_WIDTH-1:0] ps1;
    logic [PREG_IDX_WIDTH-1:0] ps2;
  } prf_rd_req_t;

  // Preg 0 is hardwired to zero and never picks up a CDB value.
  function automatic logic [31:0] bypass_operand(cdb_t                      cdb,
                                                 logic [PREG_IDX_WIDTH-1:0] ps,
                                                 logic [31:0]               prf_v);
    if (ps == '0) return '0;
    if (cdb.valid && (cdb.pd == ps)) return cdb.value;
    return prf_v;
  endfunction

endpackage

// File: rtl/prf_read_arbiter_rr_priority_picker.sv
// Combinational picker: forced requesters first in ascending index, then round-robin from
// rr_ptr_i; returns up to NumPorts ordered one-hot grants and the pointer to resume from.
module prf_read_arbiter_rr_priority_picker #(
  parameter int unsigned NumReq   = 3,
  parameter int unsigned NumPorts = 2,
  parameter int unsigned IdxW     = 2
) (
  input  logic [NumReq-1:0]                req_i,
  input  logic [NumReq-1:0]                force_i,
  input  logic [IdxW-1:0]                  rr_ptr_i,
  output logic [NumPorts-1:0][NumReq-1:0]  gnt_oh_o,
  output logic [NumReq-1:0]                gnt_o,
  output logic                             rr_hit_o,
  output logic [IdxW-1:0]                  rr_ptr_next_o
);

  always_comb begin
    int unsigned n;
    int unsigned idx;
    gnt_oh_o      = '0;
    gnt_o         = '0;
    rr_hit_o      = 1'b0;
    rr_ptr_next_o = rr_ptr_i;
    n             = 0;
    idx           = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (req_i[i] && force_i[i] && (n < NumPorts)) begin
        gnt_oh_o[n][i] = 1'b1;
        gnt_o[i]       = 1'b1;
        n++;
      end
    end
    for (int unsigned j = 0; j < NumReq; j++) begin
      idx = (32'(rr_ptr_i) + j) % NumReq;
      if (req_i[idx] && !force_i[idx] && (n < NumPorts)) begin
        gnt_oh_o[n][idx] = 1'b1;
        gnt_o[idx]       = 1'b1;
        rr_hit_o         = 1'b1;
        rr_ptr_next_o    = IdxW'((idx + 1) % NumReq);
        n++;
      end
    end
  end

endmodule

// File: rtl/prf_read_arbiter.sv
// Shares NUM_PORTS pregfile read-port pairs among NUM_REQ reservation stations and returns
// registered, CDB-bypassed operands one cycle after grant.
module prf_read_arbiter
  import prf_read_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned NUM_PORTS    = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      branch_flush,
  input  logic [NUM_REQ-1:0]                        req_valid,
  input  logic [NUM_REQ-1:0][PREG_IDX_WIDTH-1:0]    req_ps1,
  input  logic [NUM_REQ-1:0][PREG_IDX_WIDTH-1:0]    req_ps2,
  output logic [NUM_REQ-1:0]                        req_grant,
  output logic [NUM_REQ-1:0]                        rsp_valid,
  output logic [NUM_REQ-1:0][31:0]                  rsp_v1,
  output logic [NUM_REQ-1:0][31:0]                  rsp_v2,
  output logic [NUM_PORTS-1:0][PREG_IDX_WIDTH-1:0]  prf_s1,
  output logic [NUM_PORTS-1:0][PREG_IDX_WIDTH-1:0]  prf_s2,
  input  logic [NUM_PORTS-1:0][31:0]                prf_v1,
  input  logic [NUM_PORTS-1:0][31:0]                prf_v2,
  input  cdb_t                                      cdb
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  prf_rd_req_t [NUM_REQ-1:0]              rd_req;
  logic [NUM_REQ-1:0]                     pick_req, starved;
  logic [NUM_PORTS-1:0][NUM_REQ-1:0]      gnt_oh;
  logic                                   rr_hit;
  logic [IdxW-1:0]                        rr_ptr_nxt, rr_ptr_d, rr_ptr_q;
  logic [NUM_REQ-1:0][CntW-1:0]           starve_d, starve_q;
  logic [NUM_REQ-1:0]                     rsp_valid_d, rsp_valid_q;
  logic [NUM_REQ-1:0][31:0]               rsp_v1_d, rsp_v1_q, rsp_v2_d, rsp_v2_q;
  logic [NUM_PORTS-1:0][31:0]             port_v1, port_v2;

  // A flush suppresses every request so no grant and no pointer movement occur.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rd_req[i].valid = req_valid[i] && !branch_flush;
      rd_req[i].ps1   = req_ps1[i];
      rd_req[i].ps2   = req_ps2[i];
      pick_req[i]     = rd_req[i].valid;
      starved[i]      = (starve_q[i] == CntW'(STARVE_LIMIT));
    end
  end

  prf_read_arbiter_rr_priority_picker #(
    .NumReq   (NUM_REQ),
    .NumPorts (NUM_PORTS),
    .IdxW     (IdxW)
  ) u_picker (
    .req_i         (pick_req),
    .force_i       (starved),
    .rr_ptr_i      (rr_ptr_q),
    .gnt_oh_o      (gnt_oh),
    .gnt_o         (req_grant),
    .rr_hit_o      (rr_hit),
    .rr_ptr_next_o (rr_ptr_nxt)
  );

  always_comb begin
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      prf_s1[k] = '0;
      prf_s2[k] = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (gnt_oh[k][i]) begin
          prf_s1[k] = rd_req[i].ps1;
          prf_s2[k] = rd_req[i].ps2;
        end
      end
      port_v1[k] = bypass_operand(cdb, prf_s1[k], prf_v1[k]);
      port_v2[k] = bypass_operand(cdb, prf_s2[k], prf_v2[k]);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_valid_d[i] = req_grant[i];
      rsp_v1_d[i]    = rsp_v1_q[i];
      rsp_v2_d[i]    = rsp_v2_q[i];
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        if (gnt_oh[k][i]) begin
          rsp_v1_d[i] = port_v1[k];
          rsp_v2_d[i] = port_v2[k];
        end
      end
      if (branch_flush || !req_valid[i] || req_grant[i]) begin
        starve_d[i] = '0;
      end else if (!starved[i]) begin
        starve_d[i] = starve_q[i] + CntW'(1);
      end else begin
        starve_d[i] = starve_q[i];
      end
    end
    rr_ptr_d = rr_hit ? rr_ptr_nxt : rr_ptr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q    <= '0;
      starve_q    <= '0;
      rsp_valid_q <= '0;
      rsp_v1_q    <= '0;
      rsp_v2_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      starve_q    <= starve_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_v1_q    <= rsp_v1_d;
      rsp_v2_q    <= rsp_v2_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_v1    = rsp_v1_q;
  assign rsp_v2    = rsp_v2_q;

endmodule

// File: tb/tb_prf_read_arbiter.sv
// Directed bench for prf_read_arbiter: a 2-port instance for the main scenarios and a
// 1-port instance for single-port fairness.
module tb_prf_read_arbiter;
  import prf_read_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic branch_flush = 1'b0;
  logic [2:0] req_valid = '0;
  logic [2:0][PREG_IDX_WIDTH-1:0] req_ps1 = '0;
  logic [2:0][PREG_IDX_WIDTH-1:0] req_ps2 = '0;
  cdb_t cdb = '0;

  logic [2:0] req_grant, rsp_valid;
  logic [2:0][31:0] rsp_v1, rsp_v2;
  logic [1:0][PREG_IDX_WIDTH-1:0] prf_s1, prf_s2;
  logic [1:0][31:0] prf_v1, prf_v2;

  logic [2:0] grant_b, rsp_valid_b;
  logic [2:0][31:0] rsp_v1_b, rsp_v2_b;
  logic [0:0][PREG_IDX_WIDTH-1:0] prf_s1_b, prf_s2_b;
  logic [0:0][31:0] prf_v1_b, prf_v2_b;

  logic [31:0] mem [64];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign prf_v1[0]   = mem[prf_s1[0]];
  assign prf_v1[1]   = mem[prf_s1[1]];
  assign prf_v2[0]   = mem[prf_s2[0]];
  assign prf_v2[1]   = mem[prf_s2[1]];
  assign prf_v1_b[0] = mem[prf_s1_b[0]];
  assign prf_v2_b[0] = mem[prf_s2_b[0]];

  prf_read_arbiter #(.NUM_REQ(3), .NUM_PORTS(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .branch_flush(branch_flush),
    .req_valid(req_valid), .req_ps1(req_ps1), .req_ps2(req_ps2),
    .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_v1(rsp_v1), .rsp_v2(rsp_v2),
    .prf_s1(prf_s1), .prf_s2(prf_s2), .prf_v1(prf_v1), .prf_v2(prf_v2), .cdb(cdb)
  );

  prf_read_arbiter #(.NUM_REQ(3), .NUM_PORTS(1), .STARVE_LIMIT(4)) dut_b (
    .clk(clk), .rst(rst), .branch_flush(branch_flush),
    .req_valid(req_valid), .req_ps1(req_ps1), .req_ps2(req_ps2),
    .req_grant(grant_b), .rsp_valid(rsp_valid_b), .rsp_v1(rsp_v1_b), .rsp_v2(rsp_v2_b),
    .prf_s1(prf_s1_b), .prf_s2(prf_s2_b), .prf_v1(prf_v1_b), .prf_v2(prf_v2_b), .cdb(cdb)
  );

  task automatic reset_dut();
    rst = 1'b0;
    branch_flush = 1'b0;
    req_valid = '0;
    req_ps1 = '0;
    req_ps2 = '0;
    cdb = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (rsp_valid !== 3'b000) begin
      n_fail++; $display("FAIL reset_rsp_valid: got %b expected 000", rsp_valid);
    end
    n_checks++;
    if (rsp_v1 !== '0 || rsp_v2 !== '0) begin
      n_fail++; $display("FAIL reset_rsp_data: got %h/%h expected 0", rsp_v1, rsp_v2);
    end
    n_checks++;
    if (dut.rr_ptr_q !== 2'd0) begin
      n_fail++; $display("FAIL reset_rr_ptr: got %0d expected 0", dut.rr_ptr_q);
    end
    n_checks++;
    if (dut.starve_q !== '0) begin
      n_fail++; $display("FAIL reset_starve: got %h expected 0", dut.starve_q);
    end
    n_checks++;
    if (prf_s1 !== '0 || prf_s2 !== '0) begin
      n_fail++; $display("FAIL reset_prf_sel: got %h/%h expected 0", prf_s1, prf_s2);
    end
    #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_alu();
    reset_dut();
    mem[5] = 32'h11;
    mem[7] = 32'h22;
    req_valid = 3'b001;
    req_ps1[0] = 6'd5;
    req_ps2[0] = 6'd7;
    #1;
    n_checks++;
    if (req_grant !== 3'b001) begin
      n_fail++; $display("FAIL alu_grant: got %b expected 001", req_grant);
    end
    n_checks++;
    if (prf_s1[0] !== 6'd5 || prf_s2[0] !== 6'd7) begin
      n_fail++; $display("FAIL alu_port0_sel: got %0d/%0d expected 5/7", prf_s1[0], prf_s2[0]);
    end
    n_checks++;
    if (prf_s1[1] !== 6'd0 || prf_s2[1] !== 6'd0) begin
      n_fail++; $display("FAIL idle_port1_sel: got %0d/%0d expected 0/0", prf_s1[1], prf_s2[1]);
    end
    @(posedge clk); #1;
    req_valid = 3'b000;
    n_checks++;
    if (rsp_valid !== 3'b001) begin
      n_fail++; $display("FAIL alu_rsp_valid: got %b expected 001", rsp_valid);
    end
    n_checks++;
    if (rsp_v1[0] !== 32'h11 || rsp_v2[0] !== 32'h22) begin
      n_fail++; $display("FAIL alu_rsp_data: got %h/%h expected 11/22", rsp_v1[0], rsp_v2[0]);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rsp_valid !== 3'b000) begin
      n_fail++; $display("FAIL alu_rsp_one_cycle: got %b expected 000", rsp_valid);
    end
  endtask

  task automatic test_all_request();
    logic [2:0] exp_g;
    int cnt [3];
    int wait_c [3];
    int max_wait;
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      req_ps1[i] = 6'(10 + i);
      req_ps2[i] = 6'(20 + i);
      cnt[i] = 0;
      wait_c[i] = 0;
    end
    max_wait = 0;
    req_valid = 3'b111;
    for (int c = 0; c < 12; c++) begin
      #1;
      exp_g = (c % 3 == 0) ? 3'b011 : (c % 3 == 1) ? 3'b101 : 3'b110;
      n_checks++;
      if (req_grant !== exp_g) begin
        n_fail++; $display("FAIL all_grant c%0d: got %b expected %b", c, req_grant, exp_g);
      end
      if (c == 1) begin
        n_checks++;
        if (prf_s1[0] !== 6'd12 || prf_s1[1] !== 6'd10) begin
          n_fail++;
          $display("FAIL all_port_order: got %0d/%0d expected 12/10", prf_s1[0], prf_s1[1]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (req_grant[i] === 1'b1) begin
          cnt[i]++;
          wait_c[i] = 0;
        end else begin
          wait_c[i]++;
          if (wait_c[i] > max_wait) max_wait = wait_c[i];
        end
      end
      @(posedge clk); #1;
      n_checks++;
      if (rsp_valid !== exp_g) begin
        n_fail++; $display("FAIL all_rsp_valid c%0d: got %b expected %b", c, rsp_valid, exp_g);
      end
      for (int i = 0; i < 3; i++) begin
        if (exp_g[i]) begin
          n_checks++;
          if (rsp_v1[i] !== mem[10 + i] || rsp_v2[i] !== mem[20 + i]) begin
            n_fail++;
            $display("FAIL all_rsp_data c%0d r%0d: got %h/%h expected %h/%h", c, i,
                     rsp_v1[i], rsp_v2[i], mem[10 + i], mem[20 + i]);
          end
        end
      end
    end
    req_valid = 3'b000;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (cnt[i] != 8) begin
        n_fail++; $display("FAIL all_grant_count r%0d: got %0d expected 8", i, cnt[i]);
      end
    end
    n_checks++;
    if (max_wait > 1) begin
      n_fail++; $display("FAIL all_max_wait: got %0d expected <=1", max_wait);
    end
  endtask

  task automatic test_single_port();
    logic [2:0] seq [5];
    int ls_cycle;
    seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    ls_cycle = 99;
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      req_ps1[i] = 6'(10 + i);
      req_ps2[i] = 6'(20 + i);
    end
    req_valid = 3'b111;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (grant_b !== seq[c]) begin
        n_fail++; $display("FAIL p1_grant c%0d: got %b expected %b", c, grant_b, seq[c]);
      end
      if (grant_b[2] === 1'b1 && ls_cycle == 99) ls_cycle = c;
      @(posedge clk); #1;
      n_checks++;
      if (rsp_valid_b !== seq[c]) begin
        n_fail++; $display("FAIL p1_rsp_valid c%0d: got %b expected %b", c, rsp_valid_b, seq[c]);
      end
      if (c == 0) begin
        n_checks++;
        if (dut_b.starve_q[1] !== 3'd1 || dut_b.starve_q[2] !== 3'd1) begin
          n_fail++; $display("FAIL p1_starve_count: got %0d/%0d expected 1/1",
                             dut_b.starve_q[1], dut_b.starve_q[2]);
        end
      end
      if (c == 2) begin
        n_checks++;
        if (rsp_v1_b[2] !== mem[12]) begin
          n_fail++; $display("FAIL p1_ls_data: got %h expected %h", rsp_v1_b[2], mem[12]);
        end
      end
    end
    req_valid = 3'b000;
    n_checks++;
    if (ls_cycle > 4) begin
      n_fail++; $display("FAIL p1_ls_granted: got cycle %0d expected <=4", ls_cycle);
    end
  endtask

  task automatic test_cdb_bypass();
    reset_dut();
    mem[9] = 32'h0;
    req_valid = 3'b001;
    req_ps1[0] = 6'd9;
    req_ps2[0] = 6'd3;
    cdb = '{valid: 1'b1, pd: 6'd9, value: 32'hDEAD};
    @(posedge clk); #1;
    n_checks++;
    if (rsp_v1[0] !== 32'hDEAD || rsp_v2[0] !== mem[3]) begin
      n_fail++; $display("FAIL byp_hit: got %h/%h expected dead/%h", rsp_v1[0], rsp_v2[0], mem[3]);
    end
    mem[9] = 32'h99;
    req_ps1[0] = 6'd0;
    req_ps2[0] = 6'd9;
    cdb = '{valid: 1'b1, pd: 6'd0, value: 32'hBEEF};
    @(posedge clk); #1;
    n_checks++;
    if (rsp_v1[0] !== 32'h0 || rsp_v2[0] !== 32'h99) begin
      n_fail++; $display("FAIL byp_preg0: got %h/%h expected 0/99", rsp_v1[0], rsp_v2[0]);
    end
    req_valid = 3'b011;
    req_ps1[0] = 6'd9;
    req_ps1[1] = 6'd9;
    req_ps2[0] = 6'd3;
    req_ps2[1] = 6'd3;
    cdb = '{valid: 1'b0, pd: 6'd9, value: 32'hDEAD};
    @(posedge clk); #1;
    n_checks++;
    if (rsp_v1[0] !== 32'h99 || rsp_v1[1] !== 32'h99) begin
      n_fail++; $display("FAIL byp_cdb_invalid: got %h/%h expected 99/99", rsp_v1[0], rsp_v1[1]);
    end
    cdb = '{valid: 1'b1, pd: 6'd9, value: 32'hDEAD};
    @(posedge clk); #1;
    req_valid = 3'b000;
    cdb = '0;
    n_checks++;
    if (rsp_v1[0] !== 32'hDEAD || rsp_v1[1] !== 32'hDEAD) begin
      n_fail++; $display("FAIL byp_both_ports: got %h/%h expected dead/dead", rsp_v1[0], rsp_v1[1]);
    end
  endtask

  task automatic test_flush();
    reset_dut();
    req_valid = 3'b111;
    @(posedge clk); #1;
    n_checks++;
    if (dut.starve_q[2] !== 3'd1) begin
      n_fail++; $display("FAIL flush_pre_starve: got %0d expected 1", dut.starve_q[2]);
    end
    branch_flush = 1'b1;
    #1;
    n_checks++;
    if (req_grant !== 3'b000 || prf_s1 !== '0) begin
      n_fail++; $display("FAIL flush_grant: got %b sel %h expected 000 sel 0", req_grant, prf_s1);
    end
    @(posedge clk); #1;
    branch_flush = 1'b0;
    n_checks++;
    if (rsp_valid !== 3'b000) begin
      n_fail++; $display("FAIL flush_rsp_valid: got %b expected 000", rsp_valid);
    end
    n_checks++;
    if (dut.starve_q !== '0) begin
      n_fail++; $display("FAIL flush_starve: got %h expected 0", dut.starve_q);
    end
    n_checks++;
    if (dut.rr_ptr_q !== 2'd2) begin
      n_fail++; $display("FAIL flush_rr_held: got %0d expected 2", dut.rr_ptr_q);
    end
    #1;
    n_checks++;
    if (req_grant !== 3'b101) begin
      n_fail++; $display("FAIL flush_resume_grant: got %b expected 101", req_grant);
    end
    @(posedge clk); #1;
    req_valid = 3'b000;
  endtask

  task automatic test_async_reset();
    reset_dut();
    req_valid = 3'b001;
    req_ps1[0] = 6'd5;
    @(posedge clk); #1;
    req_valid = 3'b000;
    n_checks++;
    if (rsp_valid !== 3'b001 || dut.rr_ptr_q !== 2'd1) begin
      n_fail++; $display("FAIL ares_pre: got %b rr %0d expected 001 rr 1", rsp_valid, dut.rr_ptr_q);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 3'b000) begin
      n_fail++; $display("FAIL ares_immediate: got %b expected 000", rsp_valid);
    end
    n_checks++;
    if (dut.rr_ptr_q !== 2'd0) begin
      n_fail++; $display("FAIL ares_rr_ptr: got %0d expected 0", dut.rr_ptr_q);
    end
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (rsp_valid !== 3'b000 || dut.rr_ptr_q !== 2'd0) begin
      n_fail++; $display("FAIL ares_release: got %b rr %0d expected 000 rr 0",
                         rsp_valid, dut.rr_ptr_q);
    end
  endtask

  initial begin
    for (int p = 0; p < 64; p++) mem[p] = 32'hA000 + 32'(p);
    mem[0] = 32'h0;
    test_reset();
    test_single_alu();
    test_all_request();
    test_single_port();
    test_cdb_bypass();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
